// File: rtl/cnn_out_maxpool2x2.sv
// cnn_out_maxpool2x2
//   Per-channel 2x2 / stride-2 max pooling on a raster-order packed pixel
//   stream (N_CH channels of PIX_W unsigned bits, ch0 in the low bits).
//   An input frame of i_width x i_height pixels produces a
//   (i_width/2) x (i_height/2) frame in the same packing. Even-row pair
//   maxima are parked in a line buffer and combined with the odd-row pair.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   i_width        input frame width, sampled on i_start
//   i_height       input frame height, sampled on i_start
//   i_start        1-cycle pulse arming a new frame (aborts a running one)
//   i_bypass       (only with POOL_BYPASS_EN) pass pixels through unpooled,
//                  sampled on i_start
//   in_pixel       packed input pixel
//   in_valid       in_pixel valid this cycle (no back-pressure)
//   out_pixel      pooled pixel, held until the next output
//   out_valid      1-cycle pulse per pooled pixel
//   o_frame_done   1-cycle pulse the cycle after the last input pixel
//
// Build option
//   POOL_BYPASS_EN  when defined, adds i_bypass and the pass-through path.

module cnn_out_maxpool2x2 #(
  parameter int W_SIZE    = 12,
  parameter int N_CH      = 4,
  parameter int PIX_W     = 8,
  parameter int MAX_WIDTH = 2048
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [W_SIZE-1:0]       i_width,
  input  logic [W_SIZE-1:0]       i_height,
  input  logic                    i_start,
`ifdef POOL_BYPASS_EN
  input  logic                    i_bypass,
`endif
  input  logic [N_CH*PIX_W-1:0]   in_pixel,
  input  logic                    in_valid,
  output logic [N_CH*PIX_W-1:0]   out_pixel,
  output logic                    out_valid,
  output logic                    o_frame_done
);

  localparam int PW       = N_CH * PIX_W;
  localparam int LB_DEPTH = MAX_WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [31:0]       LB_DEPTH_L = LB_DEPTH;
  localparam logic [W_SIZE-1:0] W_ONE      = 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [W_SIZE-1:0] width_q, width_d, height_q, height_d;
  logic [W_SIZE-1:0] col_q, col_d, row_q, row_d;
  logic [PW-1:0]     hold_q, hold_d, pix_q, pix_d;
  logic              vld_q, vld_d, done_q, done_d;
`ifdef POOL_BYPASS_EN
  logic              bypass_q, bypass_d, bypass_cur;
`endif

  logic [PW-1:0]     lbuf [LB_DEPTH];

  // Per-channel unsigned max; each lane compared on its own, no carries.
  function automatic logic [PW-1:0] chmax(input logic [PW-1:0] a,
                                          input logic [PW-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int c = 0; c < N_CH; c++) begin
      r[c*PIX_W +: PIX_W] = (a[c*PIX_W +: PIX_W] >= b[c*PIX_W +: PIX_W]) ?
                            a[c*PIX_W +: PIX_W] : b[c*PIX_W +: PIX_W];
    end
    return r;
  endfunction

  // An i_start cycle already works in the new frame's coordinates, so a
  // pixel arriving with it is position (0,0) of the new frame.
  logic [W_SIZE-1:0] cur_w, cur_h, cur_col, cur_row;
  logic [W_SIZE-2:0] pair_idx;
  logic [LB_AW-1:0]  lb_addr;
  logic              zero_dim, accept, last_col, last_pix, pair_in_range;
  logic              lb_we;
  logic [PW-1:0]     pair_max, lb_rd;

  assign cur_w    = i_start ? i_width  : width_q;
  assign cur_h    = i_start ? i_height : height_q;
  assign cur_col  = i_start ? '0 : col_q;
  assign cur_row  = i_start ? '0 : row_q;
  assign zero_dim = (cur_w == '0) || (cur_h == '0);
  assign accept   = in_valid && (i_start || (state_q == S_RUN)) && !zero_dim;
  assign last_col = (cur_col == cur_w - W_ONE);
  assign last_pix = last_col && (cur_row == cur_h - W_ONE);
  assign pair_idx = cur_col[W_SIZE-1:1];
  assign lb_addr  = LB_AW'(pair_idx);
  // Widths beyond the buffer are unsupported; their writes are dropped.
  assign pair_in_range = (32'(pair_idx) < LB_DEPTH_L);
  assign pair_max = chmax(hold_q, in_pixel);
  assign lb_rd    = lbuf[lb_addr];

`ifdef POOL_BYPASS_EN
  assign bypass_cur = i_start ? i_bypass : bypass_q;
`endif

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    col_d    = col_q;
    row_d    = row_q;
    hold_d   = hold_q;
    pix_d    = pix_q;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    lb_we    = 1'b0;
`ifdef POOL_BYPASS_EN
    bypass_d = bypass_cur;
`endif

    if (i_start) begin
      width_d  = i_width;
      height_d = i_height;
      col_d    = '0;
      row_d    = '0;
      // An empty frame is finished the moment it is armed.
      state_d  = zero_dim ? S_IDLE : S_RUN;
      done_d   = zero_dim;
    end

    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = cur_row + W_ONE;
      end else begin
        col_d = cur_col + W_ONE;
      end
      if (last_pix) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        col_d   = '0;
        row_d   = '0;
      end

`ifdef POOL_BYPASS_EN
      if (bypass_cur) begin
        pix_d = in_pixel;
        vld_d = 1'b1;
      end else
`endif
      if (!cur_col[0]) begin
        hold_d = in_pixel;
      end else if (!cur_row[0]) begin
        lb_we = pair_in_range;
      end else begin
        pix_d = chmax(pair_max, lb_rd);
        vld_d = 1'b1;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      hold_q   <= '0;
      pix_q    <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef POOL_BYPASS_EN
      bypass_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      col_q    <= col_d;
      row_q    <= row_d;
      hold_q   <= hold_d;
      pix_q    <= pix_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
`ifdef POOL_BYPASS_EN
      bypass_q <= bypass_d;
`endif
    end
  end

  // Line buffer: even-row pair maxima, deliberately not reset
  always_ff @(posedge clk) begin
    if (lb_we) lbuf[lb_addr] <= pair_max;
  end

  assign out_pixel    = pix_q;
  assign out_valid    = vld_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_cnn_out_maxpool2x2.sv
module tb_cnn_out_maxpool2x2;

  localparam int W_SIZE = 12;
  localparam int PW     = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [W_SIZE-1:0] width = '0, height = '0;
  logic              start = 1'b0, vld = 1'b0;
  logic [PW-1:0]     pix = '0;
  logic [PW-1:0]     opix;
  logic              ovld, odone;
`ifdef POOL_BYPASS_EN
  logic              bypass = 1'b0;
`endif

  always #5 clk = ~clk;

  cnn_out_maxpool2x2 #(.W_SIZE(12), .N_CH(4), .PIX_W(8), .MAX_WIDTH(2048)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_width      (width),
    .i_height     (height),
    .i_start      (start),
`ifdef POOL_BYPASS_EN
    .i_bypass     (bypass),
`endif
    .in_pixel     (pix),
    .in_valid     (vld),
    .out_pixel    (opix),
    .out_valid    (ovld),
    .o_frame_done (odone)
  );

  int errors = 0, checks = 0, cyc_n = 0;
  logic [PW-1:0] got_q[$];
  int            got_cyc[$];
  int            exp_cyc[$];
  int            done_cnt, done_cyc;

  typedef struct packed {
    int               w;
    int               h;
    int               pat;
    bit               gaps;
    bit               swp;
    int               n_exp;
    logic [3:0][31:0] e;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, step past the edge, record what came out.
  task automatic cyc(input logic st, input logic v, input logic [PW-1:0] p);
    start = st; vld = v; pix = p;
    @(posedge clk); #1;
    cyc_n++;
    if (ovld) begin
      got_q.push_back(opix);
      got_cyc.push_back(cyc_n);
    end
    if (odone) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
  endtask

  function automatic logic [PW-1:0] pix_of(input int pat, input int idx);
    logic [7:0] a, b;
    a = 8'(idx);
    b = 8'(100 - idx);
    case (pat)
      1: case (idx)
           0:       return 32'h01FF0010;
           1:       return 32'hFF000020;
           2:       return 32'h10100030;
           default: return 32'h00800040;
         endcase
      2: return {16'h0, a, b};
      3: return {24'h0, 8'hF0 | a};
      default: return {24'h0, a};
    endcase
  endfunction

  task automatic clear_rec();
    got_q.delete(); got_cyc.delete(); exp_cyc.delete();
    done_cnt = 0; done_cyc = -1;
  endtask

  task automatic feed(input int pat, input int from, input int to, input bit gaps);
    for (int i = from; i <= to; i++) begin
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) cyc(1'b0, 1'b0, '1);
      cyc(1'b0, 1'b1, pix_of(pat, i));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
  endtask

  task automatic run_frame(input int w, input int h, input int pat, input bit gaps,
                           input bit swp, output int exp_done);
    int n, idx, r, c, start_cyc, last_acc;
    clear_rec();
    width = W_SIZE'(w); height = W_SIZE'(h);
    n = w * h; idx = 0; last_acc = -1;
    if (swp && n > 0) begin
      cyc(1'b1, 1'b1, pix_of(pat, 0));
      last_acc = cyc_n; idx = 1;
    end else begin
      cyc(1'b1, 1'b0, '0);
    end
    start_cyc = cyc_n;
    for (; idx < n; idx++) begin
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) cyc(1'b0, 1'b0, '1);
      cyc(1'b0, 1'b1, pix_of(pat, idx));
      last_acc = cyc_n;
      r = idx / w; c = idx % w;
      if (r % 2 == 1 && c % 2 == 1 && c < (w / 2) * 2 && r < (h / 2) * 2)
        exp_cyc.push_back(cyc_n);
    end
    if (n == 0) feed(0, 1, 3, 1'b0);
    idle(3);
    exp_done = (n > 0) ? last_acc : start_cyc;
  endtask

  task automatic check_frame(input string tag, input int n_exp, input logic [3:0][31:0] e,
                             input int exp_done, input bit chk_lat);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(n_exp));
    for (int k = 0; k < n_exp && k < got_q.size(); k++) begin
      chk($sformatf("%s_pix%0d", tag, k), 64'(got_q[k]), 64'(e[k]));
      if (chk_lat && k < exp_cyc.size())
        chk($sformatf("%s_lat%0d", tag, k), 64'(got_cyc[k]), 64'(exp_cyc[k]));
    end
    chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    if (n_exp > 0) chk({tag, "_hold"}, 64'(opix), 64'(e[n_exp-1]));
    chk({tag, "_idle_valid"}, 64'(ovld), 64'd0);
  endtask

  task automatic setv(input int i, input int w, input int h, input int pat, input bit gaps,
                      input bit swp, input int n, input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] e2, input logic [31:0] e3);
    vecs[i].w = w; vecs[i].h = h; vecs[i].pat = pat; vecs[i].gaps = gaps;
    vecs[i].swp = swp; vecs[i].n_exp = n;
    vecs[i].e[0] = e0; vecs[i].e[1] = e1; vecs[i].e[2] = e2; vecs[i].e[3] = e3;
  endtask

  initial begin
    int exp_done;
    logic [3:0][31:0] e4;

    //    idx  w  h  pat gaps swp n  expected outputs
    setv(0,  4, 4, 0, 0, 0, 4, 32'd5, 32'd7, 32'd13, 32'd15);
    setv(1,  2, 2, 1, 0, 0, 1, 32'hFFFF0040, 0, 0, 0);
    setv(2,  5, 3, 0, 0, 0, 2, 32'd6, 32'd8, 0, 0);
    setv(3,  5, 3, 0, 1, 0, 2, 32'd6, 32'd8, 0, 0);
    setv(4,  4, 4, 0, 1, 1, 4, 32'd5, 32'd7, 32'd13, 32'd15);
    setv(5,  6, 2, 2, 0, 0, 3, 32'h00000764, 32'h00000962, 32'h00000B60, 0);
    setv(6,  3, 3, 0, 0, 0, 1, 32'd4, 0, 0, 0);
    setv(7,  1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    setv(8,  4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    setv(9,  0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    setv(10, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setv(11, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_pixel", 64'(opix), 64'd0);
    chk("reset_out_valid", 64'(ovld), 64'd0);
    chk("reset_frame_done", 64'(odone), 64'd0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 12; i++) begin
      run_frame(vecs[i].w, vecs[i].h, vecs[i].pat, vecs[i].gaps, vecs[i].swp, exp_done);
      check_frame($sformatf("v%0d", i), vecs[i].n_exp, vecs[i].e, exp_done, 1'b1);
    end

    e4[0] = 32'd5; e4[1] = 32'd7; e4[2] = 32'd13; e4[3] = 32'd15;

    // Abort an 8x8 frame after 7 pixels, restart as 4x4 with a pixel on i_start.
    clear_rec();
    width = 12'd8; height = 12'd8;
    cyc(1'b1, 1'b0, '0);
    feed(3, 0, 6, 1'b0);
    width = 12'd4; height = 12'd4;
    cyc(1'b1, 1'b1, pix_of(0, 0));
    feed(0, 1, 15, 1'b0);
    exp_done = cyc_n;
    idle(3);
    check_frame("abort8x8", 4, e4, exp_done, 1'b0);

    // Abort where the restart pixel sits on an old odd/odd position.
    clear_rec();
    cyc(1'b1, 1'b0, '0);
    feed(3, 0, 4, 1'b0);
    cyc(1'b1, 1'b1, pix_of(0, 0));
    feed(0, 1, 15, 1'b1);
    exp_done = cyc_n;
    idle(3);
    check_frame("abort_oddodd", 4, e4, exp_done, 1'b0);

    // Asynchronous reset right after an output, mid-row.
    clear_rec();
    width = 12'd4; height = 12'd4;
    cyc(1'b1, 1'b0, '0);
    feed(0, 0, 5, 1'b0);
    chk("pre_rst_valid", 64'(ovld), 64'd1);
    chk("pre_rst_pixel", 64'(opix), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pixel", 64'(opix), 64'd0);
    chk("async_rst_valid", 64'(ovld), 64'd0);
    chk("async_rst_done", 64'(odone), 64'd0);
    idle(1);
    rst = 1'b0;
    clear_rec();
    feed(0, 6, 15, 1'b0);
    idle(2);
    chk("post_rst_ignored_count", 64'(got_q.size()), 64'd0);
    chk("post_rst_no_done", 64'(done_cnt), 64'd0);
    run_frame(vecs[1].w, vecs[1].h, vecs[1].pat, 1'b0, 1'b0, exp_done);
    check_frame("post_rst_frame", 1, vecs[1].e, exp_done, 1'b1);

`ifdef POOL_BYPASS_EN
    bypass = 1'b1;
    run_frame(4, 3, 0, 1'b1, 1'b0, exp_done);
    bypass = 1'b0;
    chk("bypass_count", 64'(got_q.size()), 64'd12);
    for (int k = 0; k < 12 && k < got_q.size(); k++)
      chk($sformatf("bypass_pix%0d", k), 64'(got_q[k]), 64'(pix_of(0, k)));
    chk("bypass_done_cycle", 64'(done_cyc), 64'(exp_done));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
